decode_stage: RTL and testbench

//  Registered LEGv8 decode stage: the successor to the combinational main decoder. Decodes the full
//  32-bit instruction into a control bundle plus register indices, with a wider opcode set.

---
 rtl/legv8_pkg.sv | 56 +++++
 rtl/opcode_table.sv | 53 +++++
 rtl/decode_stage.sv | 156 +++++++++++++++
 tb/tb_decode_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// legv8_pkg: shared LEGv8 decode definitions -- opcode patterns, control
// bundle layout, ALUOp encodings and the decode-stage FSM state type.
package legv8_pkg;

  // Full 11-bit opcodes
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;

  // Short opcodes; the low opcode bits belong to the immediate
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [5:0]  OP_B    = 6'b000101;

  localparam logic [1:0]  ALUOP_ADD   = 2'b00;
  localparam logic [1:0]  ALUOP_PASSB = 2'b01;
  localparam logic [1:0]  ALUOP_FUNCT = 2'b10;

  localparam logic [4:0]  XZR = 5'd31;

  typedef struct packed {
    logic       reg2loc;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       uncondbranch;
    logic       brnotzero;
    logic [1:0] aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Contents of the output register
  typedef struct packed {
    ctrl_t      ctrl;
    logic [4:0] rn;
    logic [4:0] rm;
    logic [4:0] rd;
    logic       illegal;
  } bundle_t;

  typedef enum logic {RUN, BUBBLE} dstate_t;

  function automatic logic is_rtype(input logic [10:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_ORR);
  endfunction

endpackage

// File: rtl/opcode_table.sv
// opcode_table: combinational Op[10:0] -> control bundle, illegal flag and
// source-usage flags used by the load-use hazard compare.
module opcode_table
  import legv8_pkg::*;
(
  input  logic [10:0] op,
  output ctrl_t       ctrl,
  output logic        is_illegal,
  output logic        is_b,
  output logic        use_rm
);

  // Priority chain is safe: the opcode patterns never overlap
  always_comb begin
    ctrl       = CTRL_NOP;
    is_illegal = 1'b0;
    is_b       = 1'b0;
    use_rm     = 1'b0;
    if (op == OP_LDUR) begin
      ctrl.alusrc   = 1'b1;
      ctrl.memtoreg = 1'b1;
      ctrl.regwrite = 1'b1;
      ctrl.memread  = 1'b1;
      ctrl.aluop    = ALUOP_ADD;
    end else if (op == OP_STUR) begin
      ctrl.reg2loc  = 1'b1;
      ctrl.alusrc   = 1'b1;
      ctrl.memwrite = 1'b1;
      ctrl.aluop    = ALUOP_ADD;
      use_rm        = 1'b1;
    end else if (is_rtype(op)) begin
      ctrl.regwrite = 1'b1;
      ctrl.aluop    = ALUOP_FUNCT;
      use_rm        = 1'b1;
    end else if ((op[10:1] == OP_ADDI) || (op[10:1] == OP_SUBI)) begin
      ctrl.alusrc   = 1'b1;
      ctrl.regwrite = 1'b1;
      ctrl.aluop    = ALUOP_FUNCT;
    end else if ((op[10:3] == OP_CBZ) || (op[10:3] == OP_CBNZ)) begin
      ctrl.reg2loc   = 1'b1;
      ctrl.branch    = 1'b1;
      ctrl.brnotzero = op[3];
      ctrl.aluop     = ALUOP_PASSB;
      use_rm         = 1'b1;
    end else if (op[10:5] == OP_B) begin
      ctrl.uncondbranch = 1'b1;
      is_b              = 1'b1;
    end else begin
      is_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered LEGv8 decode between IF/ID and ID/EX. One-entry
// valid/ready output register, load-use bubble insertion and flush.
// Optional feature macro ILLEGAL_TRAP_EN: unknown opcodes are flagged on
// `illegal` and counted (saturating) in `illegal_cnt`; otherwise both are 0
// and unknown opcodes issue as a plain NOP bundle.
module decode_stage
  import legv8_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             Reg2Loc,
  output logic             ALUSrc,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Branch,
  output logic             UncondBranch,
  output logic             BrNotZero,
  output logic [1:0]       ALUOp,
  output logic [4:0]       rn,
  output logic [4:0]       rm,
  output logic [4:0]       rd,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int         STAGES = 1;
  localparam logic [1:0] LAT    = 2'(LOAD_LAT);

  ctrl_t      dec_ctrl;
  logic       dec_ill, dec_b, dec_use_rm, use_rn, dec_trap;
  logic [4:0] in_rn, in_rm, in_rd;
  logic       unused_imm;

  opcode_table u_optab (
    .op         (instr[31:21]),
    .ctrl       (dec_ctrl),
    .is_illegal (dec_ill),
    .is_b       (dec_b),
    .use_rm     (dec_use_rm)
  );

  assign in_rn      = instr[9:5];
  assign in_rd      = instr[4:0];
  assign in_rm      = dec_ctrl.reg2loc ? instr[4:0] : instr[20:16];
  assign unused_imm = ^instr[15:10];
  // B and unknown words read no registers
  assign use_rn     = ~(dec_ill | dec_b);

`ifdef ILLEGAL_TRAP_EN
  assign dec_trap = dec_ill;
`else
  assign dec_trap = 1'b0;
`endif

  bundle_t          q, nxt;
  logic [STAGES:0]  vld_pipe;
  dstate_t          state;
  logic [1:0]       bcnt;
  logic             hazard, xfer, room, open, accept;

  assign out_valid = vld_pipe[STAGES];
  assign xfer      = out_valid & out_ready;
  assign room      = ~out_valid | out_ready;

  // Load in the output register whose result the incoming word needs
  assign hazard = instr_valid & out_valid & q.ctrl.memread & (q.rd != XZR) &
                  ((use_rn & (q.rd == in_rn)) | (dec_use_rm & (q.rd == in_rm)));

  // The edge that hands the load on already empties the register, which is
  // the first bubble; the last BUBBLE cycle reopens so the dependent word
  // lands exactly LOAD_LAT empty cycles after the load.
  assign open        = (state == RUN) | ((state == BUBBLE) & (bcnt == 2'd1));
  assign instr_ready = flush | (room & ~hazard & open);
  assign accept      = instr_valid & instr_ready & ~flush;
  assign vld_pipe[0] = accept;

  assign nxt = '{ctrl: dec_ctrl, rn: in_rn, rm: in_rm, rd: in_rd, illegal: dec_trap};

  // Output register: loads when empty or transferring, holds under stall
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe[STAGES:1] <= '0;
      q                  <= '0;
    end else if (flush) begin
      vld_pipe[STAGES:1] <= '0;
      q                  <= '0;
    end else if (room) begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      q                  <= accept ? nxt : '0;
    end
  end

  // RUN/BUBBLE FSM with bubble down-counter; flush and reset drop any remainder
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state <= RUN;
      bcnt  <= 2'd0;
    end else begin
      case (state)
        RUN: begin
          if (hazard && xfer) begin
            state <= BUBBLE;
            bcnt  <= LAT;
          end
        end
        BUBBLE: begin
          bcnt <= bcnt - 2'd1;
          if (bcnt == 2'd1) state <= RUN;
        end
        default: begin
          state <= RUN;
          bcnt  <= 2'd0;
        end
      endcase
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic [CNT_W-1:0] cnt_q;
  // Saturating count of illegal bundles handed to execute
  always_ff @(posedge clk) begin
    if (reset)                                  cnt_q <= '0;
    else if (xfer && q.illegal && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
  end
  assign illegal_cnt = cnt_q;
`else
  assign illegal_cnt = '0;
`endif

  assign illegal      = q.illegal;
  assign Reg2Loc      = q.ctrl.reg2loc;
  assign ALUSrc       = q.ctrl.alusrc;
  assign MemtoReg     = q.ctrl.memtoreg;
  assign RegWrite     = q.ctrl.regwrite;
  assign MemRead      = q.ctrl.memread;
  assign MemWrite     = q.ctrl.memwrite;
  assign Branch       = q.ctrl.branch;
  assign UncondBranch = q.ctrl.uncondbranch;
  assign BrNotZero    = q.ctrl.brnotzero;
  assign ALUOp        = q.ctrl.aluop;
  assign rn           = q.rn;
  assign rm           = q.rm;
  assign rd           = q.rd;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench. Three decode_stage instances with
// LOAD_LAT = 1, 2, 3; stimulus pushes hand-computed bundles, a negedge
// monitor pops and compares on every output transfer.
module tb_decode_stage;

  typedef struct packed {
    logic       r2l, asrc, m2r, rw, mr, mw, br, ub, bnz;
    logic [1:0] aop;
    logic [4:0] rn, rm, rd;
    logic       ill;
  } obs_t;

`ifdef ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        iv[3];
  logic [31:0] ins[3];
  logic        fl[3];
  logic        ordy[3];
  logic        ird[3];
  logic        ov[3];
  obs_t        obs[3];
  logic [1:0]  cnt[3];

  obs_t        sbq[3][$];
  int          zrun[3];
  int          gap[3];
  int          npass = 0;
  int          ntot  = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    logic       r2l, asrc, m2r, rw, mr, mw, br, ub, bnz, ill;
    logic [1:0] aop;
    logic [4:0] rn, rm, rd;
    decode_stage #(.LOAD_LAT(k + 1), .CNT_W(2)) u_dut (
      .clk(clk), .reset(rst), .instr_valid(iv[k]), .instr(ins[k]),
      .instr_ready(ird[k]), .flush(fl[k]), .out_ready(ordy[k]), .out_valid(ov[k]),
      .Reg2Loc(r2l), .ALUSrc(asrc), .MemtoReg(m2r), .RegWrite(rw), .MemRead(mr),
      .MemWrite(mw), .Branch(br), .UncondBranch(ub), .BrNotZero(bnz), .ALUOp(aop),
      .rn(rn), .rm(rm), .rd(rd), .illegal(ill), .illegal_cnt(cnt[k])
    );
    assign obs[k] = {r2l, asrc, m2r, rw, mr, mw, br, ub, bnz, aop, rn, rm, rd, ill};
  end

  function automatic obs_t mk(input logic [8:0] c, input logic [1:0] a,
                              input logic [4:0] n, input logic [4:0] m,
                              input logic [4:0] d, input logic il);
    return {c, a, n, m, d, il};
  endfunction

  // c = {Reg2Loc,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,UncondBranch,BrNotZero}
  obs_t E_ADD3, E_LDUR5, E_ADD6, E_LDUR31, E_ADD6Z, E_SUBI, E_LDUR4, E_STUR, E_LDUR0, E_B, E_CBZ, E_ILL;
  initial begin
    E_ADD3   = mk(9'b000100000, 2'b10,  1, 2,  3, 1'b0);
    E_LDUR5  = mk(9'b011110000, 2'b00,  1, 0,  5, 1'b0);
    E_ADD6   = mk(9'b000100000, 2'b10,  5, 2,  6, 1'b0);
    E_LDUR31 = mk(9'b011110000, 2'b00,  1, 0, 31, 1'b0);
    E_ADD6Z  = mk(9'b000100000, 2'b10, 31, 2,  6, 1'b0);
    E_SUBI   = mk(9'b010100000, 2'b10,  1, 0,  7, 1'b0);
    E_LDUR4  = mk(9'b011110000, 2'b00,  1, 0,  4, 1'b0);
    E_STUR   = mk(9'b110001000, 2'b00,  2, 4,  4, 1'b0);
    E_LDUR0  = mk(9'b011110000, 2'b00,  1, 0,  0, 1'b0);
    E_B      = mk(9'b000000010, 2'b00,  0, 0,  1, 1'b0);
    E_CBZ    = mk(9'b100000100, 2'b01,  1, 4,  4, 1'b0);
    E_ILL    = mk(9'b000000000, 2'b00,  0, 0,  0, TRAP);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: gap tracking and scoreboard pop on each transfer
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        obs_t e;
        if (ov[k]) begin gap[k] = zrun[k]; zrun[k] = 0; end
        else zrun[k]++;
        if (ov[k] && ordy[k]) begin
          if (sbq[k].size() == 0) begin
            ntot++;
            $display("FAIL dut%0d unexpected bundle: got %h expected none", k, obs[k]);
          end else begin
            e = sbq[k].pop_front();
            chk($sformatf("dut%0d bundle", k), 32'(obs[k]), 32'(e));
          end
        end
      end
    end
  end

  task automatic issue(input int k, input logic [31:0] w, input obs_t e);
    int n;
    n = 0;
    ins[k] = w;
    iv[k]  = 1'b1;
    @(negedge clk);
    while (!ird[k] && n < 40) begin @(negedge clk); n++; end
    if (!ird[k]) begin
      ntot++;
      $display("FAIL dut%0d issue timeout: instr_ready 0 expected 1", k);
    end else sbq[k].push_back(e);
    @(posedge clk); #1;
    iv[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ins[k] = 32'h0; fl[k] = 1'b0; ordy[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dut%0d reset out_valid", k), 32'(ov[k]), 32'd0);
      chk($sformatf("dut%0d reset bundle", k), 32'(obs[k]), 32'd0);
      chk($sformatf("dut%0d reset cnt", k), 32'(cnt[k]), 32'd0);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("dut%0d ready after reset", k), 32'(ird[k]), 32'd1);
    idle(1);

    // ADD X3,X1,X2: one-cycle latency
    issue(0, 32'h8B020023, E_ADD3);
    @(negedge clk);
    chk("add latency", 32'(ov[0]), 32'd1);
    idle(2);

    // Load-use on Rn with LOAD_LAT 1/2/3
    for (int k = 0; k < 3; k++) begin
      issue(k, 32'hF8400025, E_LDUR5);
      issue(k, 32'h8B0200A6, E_ADD6);
      idle(4);
      chk($sformatf("dut%0d load-use gap", k), 32'(gap[k]), 32'(k + 1));
    end

    // Load to XZR never stalls
    issue(0, 32'hF840003F, E_LDUR31);
    issue(0, 32'h8B0203E6, E_ADD6Z);
    idle(4);
    chk("xzr load gap", 32'(gap[0]), 32'd0);

    // STUR reads Rt as its second source
    issue(0, 32'hF8400024, E_LDUR4);
    issue(0, 32'hF8000044, E_STUR);
    idle(4);
    chk("stur rt gap", 32'(gap[0]), 32'd1);

    // B reads no registers even when its Rn field matches the load
    issue(0, 32'hF8400020, E_LDUR0);
    issue(0, 32'h14000001, E_B);
    idle(4);
    chk("b no-source gap", 32'(gap[0]), 32'd0);
    issue(0, 32'hB4000024, E_CBZ);
    idle(3);

    // Stall: SUBI X7,X1,#4 held for 3 cycles
    ordy[0] = 1'b0;
    issue(0, 32'hD1001027, E_SUBI);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall out_valid", 32'(ov[0]), 32'd1);
      chk("stall bundle", 32'(obs[0]), 32'(E_SUBI));
      chk("stall instr_ready", 32'(ird[0]), 32'd0);
    end
    @(posedge clk); #1 ordy[0] = 1'b1;
    @(negedge clk);
    chk("release instr_ready", 32'(ird[0]), 32'd1);
    idle(3);

    // Flush during BUBBLE (LOAD_LAT=3) with CBNZ offered
    issue(2, 32'hF8400025, E_LDUR5);
    ins[2] = 32'h8B0200A6; iv[2] = 1'b1;
    @(negedge clk);
    chk("hazard instr_ready", 32'(ird[2]), 32'd0);
    @(posedge clk); #1;
    ins[2] = 32'hB5000029; fl[2] = 1'b1;
    @(negedge clk);
    chk("flush instr_ready", 32'(ird[2]), 32'd1);
    chk("bubble out_valid", 32'(ov[2]), 32'd0);
    @(posedge clk); #1;
    fl[2] = 1'b0; iv[2] = 1'b0;
    @(negedge clk);
    chk("post-flush out_valid", 32'(ov[2]), 32'd0);
    chk("post-flush run ready", 32'(ird[2]), 32'd1);
    idle(3);

    // Reset in the middle of a bubble
    issue(2, 32'hF8400025, E_LDUR5);
    ins[2] = 32'h8B0200A6; iv[2] = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1; iv[2] = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("reset-bubble ready", 32'(ird[2]), 32'd1);
    chk("reset-bubble out_valid", 32'(ov[2]), 32'd0);
    idle(2);

    // Illegal words; counter saturates at 3 with CNT_W=2
    issue(0, 32'h00000000, E_ILL);
    issue(0, 32'h00000000, E_ILL);
    idle(4);
    chk("illegal cnt 2", 32'(cnt[0]), TRAP ? 32'd2 : 32'd0);
    for (int i = 0; i < 3; i++) issue(0, 32'h00000000, E_ILL);
    idle(4);
    chk("illegal cnt sat", 32'(cnt[0]), TRAP ? 32'd3 : 32'd0);

    idle(3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("dut%0d scoreboard drained", k), 32'(sbq[k].size()), 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
